// File: rtl/ps2_hex_keypad_pkg.sv
// ps2_hex_keypad_pkg
//   Shared definitions for the PS/2 -> Chip-8 hex keypad block:
//   set-2 scancode constants (prefix bytes and the 16 mapped key codes)
//   and the state encodings of the frame receiver and scancode decoder.
//   Optional feature macro used by the block: PS2_PARITY_CHECK_EN.
package ps2_hex_keypad_pkg;

    // Prefix bytes of scancode set 2
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Mapped keys: keyboard rows 1234/QWER/ASDF/ZXCV
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_Z = 8'h1A;
    localparam logic [7:0] SC_X = 8'h22;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_V = 8'h2A;

    // Frame receiver states
    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_DATA = 2'd1,
        RX_PAR  = 2'd2,
        RX_STOP = 2'd3
    } rx_state_t;

    // Scancode decoder states
    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_BRK    = 2'd1,
        D_EXT    = 2'd2,
        D_EXTBRK = 2'd3
    } dec_state_t;

endpackage

// File: rtl/ps2_hex_keypad_rx_frame.sv
// ps2_rx_frame
//   PS/2 bit-level frame receiver. Synchronises ps2_clk/ps2_data into the
//   core clock, detects ps2_clk falling edges and assembles 11-bit frames
//   (start, 8 data LSB first, parity, stop). A frame that stalls for
//   TIMEOUT_CYC clocks mid-way is discarded.
//   Optional feature: PS2_PARITY_CHECK_EN -- when defined, a byte is only
//   accepted if data+parity have odd parity; otherwise the parity bit is
//   ignored.
// Ports
//   clk, rst_n   core clock, asynchronous active-low reset
//   ps2_clk      PS/2 clock (asynchronous)
//   ps2_data     PS/2 data (asynchronous)
//   data_byte    received byte, valid while byte_valid is high
//   byte_valid   1-cycle pulse: a good frame completed
//   frame_err    1-cycle pulse: frame dropped (stop/parity error or timeout)
module ps2_rx_frame
    import ps2_hex_keypad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    rx_state_t  state;
    rx_state_t  state_next;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [15:0] tcnt;
    logic       timeout;
    logic       parity_ok;
    logic       bit_clr;
    logic       shift_en;
    logic       valid_next;
    logic       err_next;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;

    // Cycles since the last ps2_clk fall; saturates so it never wraps in idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (fall) begin
            tcnt <= '0;
        end else if (tcnt != 16'hFFFF) begin
            tcnt <= tcnt + 16'd1;
        end
    end

    assign timeout = (state != RX_IDLE) && (tcnt >= TIMEOUT_LIM);

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
        end else if (fall && state == RX_PAR) begin
            par_bit <= data_s;
        end
    end

    assign parity_ok = ^{shreg, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_next = state;
        bit_clr    = 1'b0;
        shift_en   = 1'b0;
        valid_next = 1'b0;
        err_next   = 1'b0;
        if (timeout) begin
            state_next = RX_IDLE;
            bit_clr    = 1'b1;
            err_next   = 1'b1;
        end else if (fall) begin
            case (state)
                RX_IDLE: begin
                    // A fall with data high is line noise, not a start bit.
                    if (!data_s) begin
                        state_next = RX_DATA;
                        bit_clr    = 1'b1;
                    end
                end
                RX_DATA: begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = RX_PAR;
                    end
                end
                RX_PAR: begin
                    state_next = RX_STOP;
                end
                RX_STOP: begin
                    state_next = RX_IDLE;
                    if (data_s && parity_ok) begin
                        valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: state_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            byte_valid <= valid_next;
            frame_err  <= err_next;
            if (bit_clr) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {data_s, shreg[7:1]};
            end
        end
    end

    assign data_byte = shreg;

endmodule

// File: rtl/ps2_hex_keypad.sv
// ps2_hex_keypad
//   Turns the PS/2 keyboard stream into the Chip-8 16-key hex keypad state.
//   A frame receiver (ps2_rx_frame) delivers bytes; this module decodes
//   scancode set 2 make/break/extended sequences and maps
//   1234/QWER/ASDF/ZXCV onto keys 123C/456D/789E/A0BF.
//   Optional feature: PS2_PARITY_CHECK_EN (see ps2_rx_frame).
// Ports
//   clk, rst_n   core clock (25 MHz), asynchronous active-low reset
//   ps2_clk      PS/2 clock (asynchronous)
//   ps2_data     PS/2 data (asynchronous)
//   keys         keys[k]=1 while hex key k is held
//   key_down     OR of keys, registered together with keys
//   key_event    1-cycle pulse when a key goes from released to held
//   last_key     index of the key behind the most recent key_event
//   frame_err    1-cycle pulse when a frame is dropped
module ps2_hex_keypad
    import ps2_hex_keypad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keys,
    output logic        key_down,
    output logic        key_event,
    output logic [3:0]  last_key,
    output logic        frame_err
);

    logic [7:0]  data_byte;
    logic        byte_valid;

    dec_state_t  d_state;
    dec_state_t  d_next;
    logic [15:0] keys_next;
    logic        event_next;
    logic [3:0]  last_next;
    logic        hit;
    logic [3:0]  idx;

    ps2_rx_frame #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_byte  (data_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // Scancode -> hex key index; hit=0 for everything not on the keypad.
    always_comb begin
        hit = 1'b1;
        idx = 4'h0;
        case (data_byte)
            SC_1: idx = 4'h1;
            SC_2: idx = 4'h2;
            SC_3: idx = 4'h3;
            SC_4: idx = 4'hC;
            SC_Q: idx = 4'h4;
            SC_W: idx = 4'h5;
            SC_E: idx = 4'h6;
            SC_R: idx = 4'hD;
            SC_A: idx = 4'h7;
            SC_S: idx = 4'h8;
            SC_D: idx = 4'h9;
            SC_F: idx = 4'hE;
            SC_Z: idx = 4'hA;
            SC_X: idx = 4'h0;
            SC_C: idx = 4'hB;
            SC_V: idx = 4'hF;
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        d_next     = d_state;
        keys_next  = keys;
        event_next = 1'b0;
        last_next  = last_key;
        if (byte_valid) begin
            case (d_state)
                D_IDLE: begin
                    if (data_byte == SC_BREAK) begin
                        d_next = D_BRK;
                    end else if (data_byte == SC_EXT) begin
                        d_next = D_EXT;
                    end else if (hit) begin
                        keys_next[idx] = 1'b1;
                        // Typematic repeats of a held key raise no event.
                        if (!keys[idx]) begin
                            event_next = 1'b1;
                            last_next  = idx;
                        end
                    end
                end
                D_BRK: begin
                    d_next = D_IDLE;
                    if (hit) begin
                        keys_next[idx] = 1'b0;
                    end
                end
                // Extended keys are not on the keypad: swallow the sequence.
                D_EXT: begin
                    d_next = (data_byte == SC_BREAK) ? D_EXTBRK : D_IDLE;
                end
                D_EXTBRK: begin
                    d_next = D_IDLE;
                end
                default: d_next = D_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_state   <= D_IDLE;
            keys      <= '0;
            key_down  <= 1'b0;
            key_event <= 1'b0;
            last_key  <= '0;
        end else begin
            d_state   <= d_next;
            keys      <= keys_next;
            key_down  <= |keys_next;
            key_event <= event_next;
            last_key  <= last_next;
        end
    end

endmodule

// File: tb/tb_ps2_hex_keypad.sv
// tb_ps2_hex_keypad
//   Bench for ps2_hex_keypad: drives PS/2 frames bit by bit, pushes the
//   expected last_key of every key_event to a queue and pops it when the
//   DUT pulses key_event; held-key state and frame errors are checked
//   against values worked out per test.
module tb_ps2_hex_keypad;

    localparam int HALF = 20;    // clk cycles per half PS/2 bit
    localparam int TMO  = 300;   // shortened timeout for the bench

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keys;
    logic        key_down;
    logic        key_event;
    logic [3:0]  last_key;
    logic        frame_err;

    int checks;
    int errors;
    int ev_cnt;
    int ferr_cnt;
    logic [3:0] exp_q[$];

    ps2_hex_keypad #(
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keys      (keys),
        .key_down  (key_down),
        .key_event (key_event),
        .last_key  (last_key),
        .frame_err (frame_err)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every key_event pops one expected key index.
    always @(negedge clk) begin
        if (rst_n && key_event) begin
            ev_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_event", {28'd0, last_key}, 32'hFFFF_FFFF);
            end else begin
                check("event_last_key", {28'd0, last_key}, {28'd0, exp_q.pop_front()});
            end
        end
        if (rst_n && frame_err) begin
            ferr_cnt++;
        end
    end

    // ---------------- drivers ----------------
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] code, input logic [3:0] k);
        exp_q.push_back(k);
        send_byte(code, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_keys"}, {16'd0, keys}, 32'd0);
        check({tag, "_key_down"}, {31'd0, key_down}, 32'd0);
        check({tag, "_key_event"}, {31'd0, key_event}, 32'd0);
        check({tag, "_last_key"}, {28'd0, last_key}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    int ev0;
    int fe0;

    initial begin
        checks   = 0;
        errors   = 0;
        ev_cnt   = 0;
        ferr_cnt = 0;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        do_reset();

        // 1: make/break of key '1'
        ev0 = ev_cnt;
        press(8'h16, 4'h1);
        check("t1_keys", {16'd0, keys}, 32'h0002);
        check("t1_key_down", {31'd0, key_down}, 32'd1);
        check("t1_last_key", {28'd0, last_key}, 32'h1);
        check("t1_events", ev_cnt - ev0, 32'd1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h16, 1'b0);
        check("t1_brk_keys", {16'd0, keys}, 32'h0000);
        check("t1_brk_key_down", {31'd0, key_down}, 32'd0);
        check("t1_brk_events", ev_cnt - ev0, 32'd1);

        // 2: typematic repeats give a single event
        do_reset();
        ev0 = ev_cnt;
        press(8'h16, 4'h1);
        for (int i = 0; i < 2; i++) begin
            send_byte(8'h16, 1'b0);
            check("t2_keys", {16'd0, keys}, 32'h0002);
        end
        check("t2_events", ev_cnt - ev0, 32'd1);

        // 3: two keys held, release of one keeps last_key
        do_reset();
        press(8'h15, 4'h4);
        press(8'h2A, 4'hF);
        check("t3_keys", {16'd0, keys}, 32'h8010);
        check("t3_last_key", {28'd0, last_key}, 32'hF);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h15, 1'b0);
        check("t3_brk_keys", {16'd0, keys}, 32'h8000);
        check("t3_brk_last_key", {28'd0, last_key}, 32'hF);

        // 4: partial frame times out, next frame is clean
        do_reset();
        fe0 = ferr_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TMO + 100) @(negedge clk);
        check("t4_timeout_err", ferr_cnt - fe0, 32'd1);
        check("t4_keys_idle", {16'd0, keys}, 32'h0000);
        press(8'h1C, 4'h7);
        check("t4_keys", {16'd0, keys}, 32'h0080);
        check("t4_last_key", {28'd0, last_key}, 32'h7);
        check("t4_err_total", ferr_cnt - fe0, 32'd1);

        // 5: flipped parity
        do_reset();
        fe0 = ferr_cnt;
`ifdef PS2_PARITY_CHECK_EN
        send_byte(8'h1E, 1'b1);
        check("t5_par_err", ferr_cnt - fe0, 32'd1);
        check("t5_keys", {16'd0, keys}, 32'h0000);
`else
        exp_q.push_back(4'h2);
        send_byte(8'h1E, 1'b1);
        check("t5_par_err", ferr_cnt - fe0, 32'd0);
        check("t5_keys", {16'd0, keys}, 32'h0004);
`endif

        // bad stop bit always errors
        fe0 = ferr_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        check("t5_stop_err", ferr_cnt - fe0, 32'd1);

        // 6: extended codes ignored, then mid-frame reset
        do_reset();
        ev0 = ev_cnt;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h16, 1'b0);
        check("t6_ext_keys", {16'd0, keys}, 32'h0000);
        check("t6_ext_events", ev_cnt - ev0, 32'd0);
        send_byte(8'hAA, 1'b0);
        press(8'h22, 4'h0);
        check("t6_keys", {16'd0, keys}, 32'h0001);
        check("t6_key_down", {31'd0, key_down}, 32'd1);
        check("t6_last_key", {28'd0, last_key}, 32'h0);
        check("t6_events", ev_cnt - ev0, 32'd1);

        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        fe0 = ferr_cnt;
        repeat (TMO + 50) @(negedge clk);
        check("t6_post_rst_err", ferr_cnt - fe0, 32'd0);
        check("t6_post_rst_keys", {16'd0, keys}, 32'h0000);
        press(8'h16, 4'h1);
        check("t6_recover_keys", {16'd0, keys}, 32'h0002);

        check("pending_events", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
